// File: rtl/counter32_checker.sv
// Receive-side monitor for the 32-bit mode counter: runs its own reference model and
// flags any Q/rco/load mismatch. Optional macro CHK_RESYNC_EN: resync the model on a Q mismatch.
module counter32_checker #(
    parameter int WIDTH     = 32,
    parameter int DW        = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DW-1:0]        D,
    input  logic [WIDTH-1:0]     Q,
    input  logic                 rco,
    input  logic                 load,
    output logic                 chk_valid,
    output logic                 error,
    output logic [2:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 sticky_err
);

    typedef enum logic [1:0] {S_RESET, S_ARM, S_CHECK} state_t;

    state_t           state, state_nxt;
    logic             compare_en;
    logic [WIDTH-1:0] exp_q, exp_q_nxt, base_q;
    logic             exp_rco, exp_rco_nxt;
    logic             exp_load, exp_load_nxt;
    logic             q_bad, rco_bad, load_bad, mismatch;

    always_ff @(posedge clk) begin
        // NOTE: registered state always uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= S_RESET;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        compare_en = 1'b0;
        case (state)
            S_RESET: state_nxt = S_ARM;
            S_ARM: begin
                compare_en = 1'b1;
                state_nxt  = S_CHECK;
            end
            S_CHECK: compare_en = 1'b1;
            default: state_nxt = S_RESET;
        endcase
    end

    assign q_bad    = compare_en && (Q    != exp_q);
    assign rco_bad  = compare_en && (rco  != exp_rco);
    assign load_bad = compare_en && (load != exp_load);
    assign mismatch = q_bad | rco_bad | load_bad;

`ifdef CHK_RESYNC_EN
    // Follow the counter after a Q deviation so one glitch costs a single error.
    assign base_q = q_bad ? Q : exp_q;
`else
    assign base_q = exp_q;
`endif

    always_comb begin
        exp_q_nxt    = base_q;
        exp_rco_nxt  = 1'b0;
        exp_load_nxt = 1'b0;
        if (enable) begin
            case (mode)
                2'b00: begin
                    exp_q_nxt   = base_q + WIDTH'(1);
                    exp_rco_nxt = (base_q == '1);
                end
                2'b01: begin
                    exp_q_nxt   = base_q - WIDTH'(1);
                    exp_rco_nxt = (base_q == '0);
                end
                2'b10: begin
                    exp_q_nxt   = base_q - WIDTH'(3);
                    exp_rco_nxt = (base_q < WIDTH'(3));
                end
                default: begin
                    exp_q_nxt    = {{(WIDTH-DW){1'b0}}, D};
                    exp_load_nxt = 1'b1;
                end
            endcase
        end
    end

    // A reset edge discards any comparison in flight: nothing is recorded.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q      <= '0;
            exp_rco    <= 1'b0;
            exp_load   <= 1'b0;
            chk_valid  <= 1'b0;
            error      <= 1'b0;
            err_code   <= 3'b000;
            err_count  <= '0;
            sticky_err <= 1'b0;
        end else begin
            exp_q     <= exp_q_nxt;
            exp_rco   <= exp_rco_nxt;
            exp_load  <= exp_load_nxt;
            chk_valid <= compare_en;
            error     <= mismatch;
            if (mismatch) begin
                err_code   <= {q_bad, rco_bad, load_bad};
                sticky_err <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter32_checker.sv
// Self-checking bench for counter32_checker: a vector table for the basic sequence and
// wrap/borrow boundaries, hand-written corner cases, then random stimulus vs. a model.
module tb_counter32_checker;

    logic        clk = 1'b0;
    logic        reset, enable, rco, load;
    logic [1:0]  mode;
    logic [3:0]  D;
    logic [31:0] Q;
    logic        chk_valid, error, sticky_err;
    logic [2:0]  err_code;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;

`ifdef CHK_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    always #5 clk = ~clk;

    counter32_checker dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
        .Q(Q), .rco(rco), .load(load),
        .chk_valid(chk_valid), .error(error), .err_code(err_code),
        .err_count(err_count), .sticky_err(sticky_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural counter, computed with wide signed arithmetic.
    typedef struct {
        logic [31:0] q;
        logic        rco;
        logic        load;
    } cnt_t;

    function automatic cnt_t ctr_next(cnt_t cur, logic en, logic [1:0] m, logic [3:0] d);
        cnt_t   n;
        longint v;
        n.q    = cur.q;
        n.rco  = 1'b0;
        n.load = 1'b0;
        if (en) begin
            case (m)
                2'd0: begin v = longint'(cur.q) + 1; n.rco = (v > 64'hFFFF_FFFF); n.q = v[31:0]; end
                2'd1: begin v = longint'(cur.q) - 1; n.rco = (v < 0); n.q = v[31:0]; end
                2'd2: begin v = longint'(cur.q) - 3; n.rco = (v < 0); n.q = v[31:0]; end
                default: begin n.q = 32'(d); n.load = 1'b1; end
            endcase
        end
        return n;
    endfunction

    // Model of the counter being observed, and of what the checker should report.
    cnt_t        dut_c, mod_c;
    int          since;
    logic        m_valid, m_err, m_sticky;
    logic [2:0]  m_code;
    logic [15:0] m_cnt;

    task automatic cycle(input logic rst_i, input logic en_i, input logic [1:0] mode_i,
                         input logic [3:0] d_i, input logic [31:0] q_x,
                         input logic rco_x, input logic load_x, input bit persist);
        logic [31:0] q_obs;
        logic        qb, rb, lb;
        cnt_t        base;
        q_obs  = dut_c.q ^ q_x;
        reset  = rst_i;
        enable = en_i;
        mode   = mode_i;
        D      = d_i;
        Q      = q_obs;
        rco    = dut_c.rco ^ rco_x;
        load   = dut_c.load ^ load_x;
        if (rst_i) begin
            dut_c    = '{32'd0, 1'b0, 1'b0};
            mod_c    = '{32'd0, 1'b0, 1'b0};
            since    = 0;
            m_valid  = 1'b0;
            m_err    = 1'b0;
            m_code   = 3'b000;
            m_cnt    = 16'd0;
            m_sticky = 1'b0;
        end else begin
            m_valid = (since >= 1);
            qb      = m_valid && (Q !== mod_c.q);
            rb      = m_valid && (rco !== mod_c.rco);
            lb      = m_valid && (load !== mod_c.load);
            m_err   = qb | rb | lb;
            if (m_err) begin
                m_code   = {qb, rb, lb};
                m_sticky = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            base = mod_c;
            if (RESYNC && qb) base.q = Q;
            mod_c = ctr_next(base, en_i, mode_i, d_i);
            base = dut_c;
            if (persist) base.q = q_obs;
            dut_c = ctr_next(base, en_i, mode_i, d_i);
            if (since < 2) since++;
        end
        @(posedge clk);
        #1;
        check("chk_valid", chk_valid, m_valid);
        check("error", error, m_err);
        check("err_code", err_code, m_code);
        check("err_count", err_count, m_cnt);
        check("sticky_err", sticky_err, m_sticky);
    endtask

    typedef struct {
        logic        rst, en;
        logic [1:0]  mode;
        logic [3:0]  d;
        logic [31:0] q;
        logic        r, l;
        logic        valid, err;
        logic [2:0]  code;
        logic [15:0] cnt;
        logic        sticky;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        reset = 1'b1; enable = 1'b0; mode = 2'd0; D = 4'd0; Q = 32'd0; rco = 1'b0; load = 1'b0;

        // Reset, count 1..10, load F then 0, down-3 through zero, up through the wrap,
        // hold, down-3 from 1 with a missing rco.
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        for (int k = 1; k <= 10; k++) tbl.push_back('{0, 1, 0, 0, k, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 3, 4'hF, 11, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 3, 4'h0, 32'hF, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 2, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 32'hFFFF_FFFD, 1, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 32'hFFFF_FFFE, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 32'h0, 1, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 32'h1, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 2, 0, 32'h1, 0, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 1, 1, 3'b010, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 32'hFFFF_FFFE, 0, 0, 1, 0, 3'b010, 1, 1});

        foreach (tbl[i]) begin
            v      = tbl[i];
            reset  = v.rst;
            enable = v.en;
            mode   = v.mode;
            D      = v.d;
            Q      = v.q;
            rco    = v.r;
            load   = v.l;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), chk_valid, v.valid);
            check($sformatf("vec%0d_error", i), error, v.err);
            check($sformatf("vec%0d_code", i), err_code, v.code);
            check($sformatf("vec%0d_count", i), err_count, v.cnt);
            check($sformatf("vec%0d_sticky", i), sticky_err, v.sticky);
        end

        // Persistent Q bit-flip at count 5, then 10 more cycles.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("flip_pre_q", dut_c.q, 32'd5);
        cycle(0, 1, 0, 0, 32'h10, 0, 0, 1);
        check("flip_first_err", error, 1'b1);
        check("flip_first_code", err_code, 3'b100);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("flip_err_count", err_count, RESYNC ? 16'd1 : 16'd11);

        // All three fields wrong in one cycle: one error, one count, code 111.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 32'h1, 1, 1, 0);
        check("multi_code", err_code, 3'b111);
        check("multi_count", err_count, 16'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Saturate the error counter with a stuck-high rco.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65539; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0);
        check("sat_count", err_count, 16'hFFFF);
        check("sat_error", error, 1'b1);
        check("sat_code", err_code, 3'b010);

        // Reset while a mismatch is on the inputs: nothing recorded, re-arm.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 32'h4, 1, 0, 0);
        check("rst_mid_error", error, 1'b0);
        check("rst_mid_valid", chk_valid, 1'b0);
        check("rst_mid_count", err_count, 16'd0);
        check("rst_mid_sticky", sticky_err, 1'b0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("rearm_valid0", chk_valid, 1'b0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("rearm_valid1", chk_valid, 1'b1);
        check("rearm_error", error, 1'b0);

        // Random stimulus with occasional injected faults and resets.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] qx;
            logic        rx, lx, rs;
            bit          ps;
            int          r;
            qx = 32'd0; rx = 1'b0; lx = 1'b0; ps = 1'b0;
            r  = $urandom_range(0, 15);
            if (r == 0) begin
                qx = 32'd1 << $urandom_range(0, 31);
                ps = $urandom_range(0, 1) == 1;
            end
            if (r == 1) rx = 1'b1;
            if (r == 2) lx = 1'b1;
            rs = ($urandom_range(0, 63) == 0);
            cycle(rs, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), qx, rx, lx, ps);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
